// File: rtl/psl_command_responder.sv
// PSL-side CAPI command responder: a command FIFO feeding a single-command FSM that moves
// cache lines between a backdoor-loadable memory model and the AFU buffer interface.
package psl_command_responder_pkg;
    localparam logic [12:0] CMD_READ_CL_NA = 13'h0A00;
    localparam logic [12:0] CMD_WRITE_NA   = 13'h0D00;
    localparam logic [7:0]  RSP_DONE       = 8'h00;
    localparam logic [7:0]  RSP_AERROR     = 8'h01;
    localparam logic [7:0]  RSP_FAILED     = 8'h08;

    // Byte 0 of any data vector is its most significant byte.
    typedef struct packed {
        logic        valid;
        logic [12:0] command;
        logic [7:0]  tag;
        logic [11:0] size;
        logic [63:0] address;
    } CommandInterfaceOutput;

    typedef struct packed {
        logic [511:0] read_data;
    } BufferInterfaceOutput;

    typedef struct packed {
        logic         write_valid;
        logic [7:0]   write_tag;
        logic [5:0]   write_address;
        logic [511:0] write_data;
        logic         write_parity;
        logic         read_valid;
        logic [7:0]   read_tag;
        logic         read_tag_parity;
        logic [5:0]   read_address;
    } BufferInterfaceInput;

    typedef struct packed {
        logic       valid;
        logic [7:0] tag;
        logic       tag_parity;
        logic [7:0] response;
        logic [8:0] credits;
    } ResponseInterface;

    typedef struct packed {
        logic [12:0] command;
        logic [7:0]  tag;
        logic [11:0] size;
        logic [63:0] address;
    } cmd_entry_t;
endpackage

module psl_command_responder
    import psl_command_responder_pkg::*;
#(
    parameter int MEM_LINES    = 64,
    parameter int CMD_DEPTH    = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  CommandInterfaceOutput        command_in,
    input  BufferInterfaceOutput         buffer_in,
    output BufferInterfaceInput          buffer_out,
    output ResponseInterface             response,
    input  logic                         mem_load_en,
    input  logic [$clog2(MEM_LINES)-1:0] mem_load_line,
    input  logic [1023:0]                mem_load_data,
    input  logic [$clog2(MEM_LINES)-1:0] mem_peek_line,
    output logic [1023:0]                mem_peek_data,
    output logic                         overflow
);
    localparam int LINE_W = $clog2(MEM_LINES);
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, RD_BEAT0, RD_BEAT1, WR_REQ0, WR_REQ1, WR_WAIT, RESPOND} state_t;

    state_t              r_state;
    cmd_entry_t          r_fifo [CMD_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic [1023:0]       r_mem [MEM_LINES];
    logic [7:0]          r_tag;
    logic [LINE_W-1:0]   r_line;
    logic [6:0]          r_offset;
    logic [7:0]          r_size;
    logic [511:0]        r_stage_hi;
    logic [READ_LATENCY-1:0] r_pv, r_pa;
    BufferInterfaceInput r_buf;
    ResponseInterface    r_rsp;

    logic              w_full, w_empty, w_push, w_pop;
    cmd_entry_t        w_head;
    logic [6:0]        w_line_field, w_offset;
    logic [LINE_W-1:0] w_head_line;
    logic              w_cmd_ok, w_decode_ok, w_is_read;
    logic [7:0]        w_err_code;
    logic              w_samp_first, w_samp_last, w_merge_en;
    logic [1023:0]     w_mask, w_merged;

    assign w_full   = (r_count == CNT_W'(CMD_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = command_in.valid && !w_full;
    assign w_pop    = (r_state == IDLE) && !w_empty;
    assign w_head   = r_fifo[r_rd_ptr];

    assign w_line_field = w_head.address[13:7];
    assign w_offset     = w_head.address[6:0];
    assign w_head_line  = w_line_field[LINE_W-1:0];
    assign w_is_read    = (w_head.command == CMD_READ_CL_NA);
    assign w_cmd_ok     = w_is_read || (w_head.command == CMD_WRITE_NA);
    assign w_decode_ok  = (w_head.address[63:14] == '0)
                       && (32'(w_line_field) < 32'(MEM_LINES))
                       && (w_head.size != '0) && (w_head.size <= 12'd128)
                       && ((13'(w_offset) + 13'(w_head.size)) <= 13'd128);
    assign w_err_code   = w_cmd_ok ? RSP_AERROR : RSP_FAILED;

    // Read data returns READ_LATENCY cycles after each request; the pipe tracks which half.
    assign w_samp_first = r_pv[READ_LATENCY-1] && !r_pa[READ_LATENCY-1];
    assign w_samp_last  = r_pv[READ_LATENCY-1] &&  r_pa[READ_LATENCY-1];
    assign w_merge_en   = (r_state == WR_WAIT) && w_samp_last;

    always_comb begin
        w_mask = '0;
        for (int unsigned b = 0; b < 128; b++)
            if (b >= 32'(r_offset) && b < 32'(r_offset) + 32'(r_size))
                w_mask[1023 - 8*b -: 8] = 8'hFF;
    end

    // The low half is merged straight from the bus on the cycle it arrives.
    assign w_merged = (r_mem[r_line] & ~w_mask) | ({r_stage_hi, buffer_in.read_data} & w_mask);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{command: command_in.command, tag: command_in.tag,
                                      size: command_in.size, address: command_in.address};
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (command_in.valid && w_full)
                r_overflow <= 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_rsp      <= '0;
            r_tag      <= '0;
            r_line     <= '0;
            r_offset   <= '0;
            r_size     <= '0;
            r_stage_hi <= '0;
            r_pv       <= '0;
            r_pa       <= '0;
        end else begin
            r_buf <= '0;
            r_rsp <= '0;
            r_pv[0] <= r_buf.read_valid;
            r_pa[0] <= r_buf.read_address[0];
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
            if (w_samp_first)
                r_stage_hi <= buffer_in.read_data;

            case (r_state)
                IDLE: if (w_pop) begin
                    r_tag    <= w_head.tag;
                    r_line   <= w_head_line;
                    r_offset <= w_offset;
                    r_size   <= w_head.size[7:0];
                    if (!w_cmd_ok || !w_decode_ok) begin
                        r_state            <= RESPOND;
                        r_rsp.valid        <= 1'b1;
                        r_rsp.tag          <= w_head.tag;
                        r_rsp.tag_parity   <= ~^w_head.tag;
                        r_rsp.response     <= w_err_code;
                        r_rsp.credits      <= 9'd1;
                    end else if (w_is_read) begin
                        r_state              <= RD_BEAT0;
                        r_buf.write_valid    <= 1'b1;
                        r_buf.write_tag      <= w_head.tag;
                        r_buf.write_address  <= 6'd0;
                        r_buf.write_data     <= r_mem[w_head_line][1023:512];
                        r_buf.write_parity   <= ~^r_mem[w_head_line][1023:512];
                    end else begin
                        r_state               <= WR_REQ0;
                        r_buf.read_valid      <= 1'b1;
                        r_buf.read_tag        <= w_head.tag;
                        r_buf.read_tag_parity <= ~^w_head.tag;
                        r_buf.read_address    <= 6'd0;
                    end
                end
                RD_BEAT0: begin
                    r_state             <= RD_BEAT1;
                    r_buf.write_valid   <= 1'b1;
                    r_buf.write_tag     <= r_tag;
                    r_buf.write_address <= 6'd1;
                    r_buf.write_data    <= r_mem[r_line][511:0];
                    r_buf.write_parity  <= ~^r_mem[r_line][511:0];
                end
                WR_REQ0: begin
                    r_state               <= WR_REQ1;
                    r_buf.read_valid      <= 1'b1;
                    r_buf.read_tag        <= r_tag;
                    r_buf.read_tag_parity <= ~^r_tag;
                    r_buf.read_address    <= 6'd1;
                end
                WR_REQ1: r_state <= WR_WAIT;
                RD_BEAT1, WR_WAIT: if (r_state == RD_BEAT1 || w_samp_last) begin
                    r_state          <= RESPOND;
                    r_rsp.valid      <= 1'b1;
                    r_rsp.tag        <= r_tag;
                    r_rsp.tag_parity <= ~^r_tag;
                    r_rsp.response   <= RSP_DONE;
                    r_rsp.credits    <= 9'd1;
                end
                RESPOND: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Backdoor load is issued last so it overrides a merge to the same line.
    always_ff @(posedge clock) begin
        if (w_merge_en)
            r_mem[r_line] <= w_merged;
        if (mem_load_en)
            r_mem[mem_load_line] <= mem_load_data;
    end

    assign mem_peek_data = r_mem[mem_peek_line];
    assign buffer_out    = r_buf;
    assign response      = r_rsp;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_psl_command_responder.sv
// Directed and randomized checks of psl_command_responder against a byte-array memory model
// and response rules computed from addresses with plain arithmetic.
module tb_psl_command_responder;
    import psl_command_responder_pkg::*;

    localparam int MEM_LINES    = 64;
    localparam int CMD_DEPTH    = 4;
    localparam int READ_LATENCY = 1;

    logic                  clock, reset;
    CommandInterfaceOutput command_in;
    BufferInterfaceOutput  buffer_in;
    BufferInterfaceInput   buffer_out;
    ResponseInterface      response;
    logic                  mem_load_en;
    logic [5:0]            mem_load_line, mem_peek_line;
    logic [1023:0]         mem_load_data, mem_peek_data;
    logic                  overflow;

    psl_command_responder #(.MEM_LINES(MEM_LINES), .CMD_DEPTH(CMD_DEPTH), .READ_LATENCY(READ_LATENCY)) dut (
        .clock(clock), .reset(reset), .command_in(command_in), .buffer_in(buffer_in),
        .buffer_out(buffer_out), .response(response), .mem_load_en(mem_load_en),
        .mem_load_line(mem_load_line), .mem_load_data(mem_load_data),
        .mem_peek_line(mem_peek_line), .mem_peek_data(mem_peek_data), .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [MEM_LINES][128];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            int first = 0;
            errors++;
            for (int b = 127; b >= 0; b--)
                if (obs[1023-8*b -: 8] !== exp[1023-8*b -: 8]) first = b;
            $error("FAIL %s: byte %0d observed %02h expected %02h", tag, first,
                   obs[1023-8*first -: 8], exp[1023-8*first -: 8]);
        end
    endtask

    function automatic logic [1023:0] mdl_line(input int l);
        logic [1023:0] v;
        for (int b = 0; b < 128; b++) v[1023-8*b -: 8] = mdl[l][b];
        return v;
    endfunction

    function automatic logic [1023:0] rand_line();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [7:0] calc_code(input logic [12:0] c, input logic [11:0] sz, input logic [63:0] a);
        longint unsigned off = a % 128;
        if (c != CMD_READ_CL_NA && c != CMD_WRITE_NA) return 8'h08;
        if (a >= 64'(MEM_LINES * 128)) return 8'h01;
        if (sz < 1 || sz > 128 || off + sz > 128) return 8'h01;
        return 8'h00;
    endfunction

    // AFU side of the buffer read path: data for a request seen in cycle c is driven in c+READ_LATENCY.
    logic [1023:0] afu_line;
    bit            hv [256];
    bit            ha [256];
    int            cyc = 0;

    initial begin
        buffer_in = '0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (hv[(cyc - READ_LATENCY) & 255])
                buffer_in.read_data = ha[(cyc - READ_LATENCY) & 255] ? afu_line[511:0] : afu_line[1023:512];
            else
                buffer_in.read_data = {16{$urandom}};
        end
    end

    initial forever begin
        @(negedge clock);
        hv[cyc & 255] = buffer_out.read_valid;
        ha[cyc & 255] = buffer_out.read_address[0];
    end

    logic [511:0] bd [2];
    int           bk [2], rk [2];
    logic [5:0]   ba [2], ra [2];
    logic [7:0]   bt [2], rtg [2];
    logic         bp [2], rtp [2];
    int           nbeats, nreq, rsp_k;
    ResponseInterface rsp_cap;

    task automatic drive_cmd(input logic [12:0] c, input logic [7:0] t, input logic [11:0] s, input logic [63:0] a);
        command_in.valid   = 1'b1;
        command_in.command = c;
        command_in.tag     = t;
        command_in.size    = s;
        command_in.address = a;
    endtask

    task automatic load_line(input int l, input logic [1023:0] d);
        @(posedge clock); #2;
        mem_load_en = 1'b1; mem_load_line = 6'(l); mem_load_data = d;
        @(posedge clock); #2;
        mem_load_en = 1'b0;
        for (int b = 0; b < 128; b++) mdl[l][b] = d[1023-8*b -: 8];
    endtask

    task automatic peek_check(input string tag, input int l);
        mem_peek_line = 6'(l);
        #1;
        check_line(tag, mem_peek_data, mdl_line(l));
    endtask

    task automatic run_cmd(input string name, input logic [12:0] c, input logic [7:0] t,
                           input logic [11:0] s, input logic [63:0] a, input logic [1023:0] wd);
        logic [7:0] exp_code = calc_code(c, s, a);
        int l = int'(a / 128) % MEM_LINES;
        int off = int'(a % 128);
        afu_line = wd;
        nbeats = 0; nreq = 0; rsp_k = -1; rsp_cap = '0;
        @(posedge clock); #2;
        drive_cmd(c, t, s, a);
        @(posedge clock); #2;
        command_in.valid = 1'b0;
        for (int k = 1; k <= 20 + READ_LATENCY; k++) begin
            @(negedge clock);
            if (buffer_out.write_valid) begin
                if (nbeats < 2) begin
                    bd[nbeats] = buffer_out.write_data; bk[nbeats] = k; ba[nbeats] = buffer_out.write_address;
                    bt[nbeats] = buffer_out.write_tag;  bp[nbeats] = buffer_out.write_parity;
                end
                nbeats++;
            end
            if (buffer_out.read_valid) begin
                if (nreq < 2) begin
                    rk[nreq] = k; ra[nreq] = buffer_out.read_address;
                    rtg[nreq] = buffer_out.read_tag; rtp[nreq] = buffer_out.read_tag_parity;
                end
                nreq++;
            end
            if (response.valid) begin
                rsp_k = k; rsp_cap = response;
                break;
            end
        end
        check({name, ".rsp_seen"}, 64'(rsp_k > 0), 1);
        check({name, ".code"}, rsp_cap.response, exp_code);
        check({name, ".tag"}, rsp_cap.tag, t);
        check({name, ".tag_par"}, rsp_cap.tag_parity, ~^t);
        check({name, ".credits"}, rsp_cap.credits, 1);
        if (exp_code == 8'h00 && c == CMD_READ_CL_NA) begin
            check({name, ".nbeats"}, nbeats, 2);
            check({name, ".nreq"}, nreq, 0);
            check({name, ".rsp_lat"}, rsp_k, 4);
            for (int i = 0; i < 2; i++) begin
                check({name, ".beat_cyc"}, bk[i], 2 + i);
                check({name, ".beat_addr"}, ba[i], i);
                check({name, ".beat_tag"}, bt[i], t);
                check({name, ".beat_par"}, bp[i], ~^bd[i]);
                check_line({name, ".beat_data"}, {512'b0, bd[i]},
                           {512'b0, (i == 0) ? mdl_line(l)[1023:512] : mdl_line(l)[511:0]});
            end
        end else if (exp_code == 8'h00) begin
            check({name, ".nreq"}, nreq, 2);
            check({name, ".nbeats"}, nbeats, 0);
            check({name, ".rsp_lat"}, rsp_k, 4 + READ_LATENCY);
            for (int i = 0; i < 2; i++) begin
                check({name, ".req_cyc"}, rk[i], 2 + i);
                check({name, ".req_addr"}, ra[i], i);
                check({name, ".req_tag"}, rtg[i], t);
                check({name, ".req_tpar"}, rtp[i], ~^t);
            end
            for (int b = off; b < off + int'(s); b++) mdl[l][b] = wd[1023-8*b -: 8];
        end else begin
            check({name, ".err_nbeats"}, nbeats, 0);
            check({name, ".err_nreq"}, nreq, 0);
        end
        if (a < 64'(MEM_LINES * 128)) peek_check({name, ".mem"}, l);
        peek_check({name, ".mem_other"}, int'($urandom % MEM_LINES));
    endtask

    initial begin
        logic [1023:0] asc, d;
        logic [7:0]    got [$];
        int            nrsp;

        reset = 1'b1; command_in = '0; mem_load_en = 1'b0; mem_load_line = '0;
        mem_load_data = '0; mem_peek_line = '0; afu_line = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset.buf_zero", 64'(buffer_out === '0), 1);
        check("reset.rsp_zero", 64'(response === '0), 1);
        check("reset.overflow", overflow, 0);
        @(posedge clock); #2;
        reset = 1'b0;

        for (int b = 0; b < 128; b++) asc[1023-8*b -: 8] = 8'(b);
        for (int l = 0; l < MEM_LINES; l++) load_line(l, (l == 2) ? asc : rand_line());

        run_cmd("read_line2", CMD_READ_CL_NA, 8'h01, 12'd128, 64'h100, '0);
        check("read_line2.first_byte", bd[0][511:504], 8'h00);
        check("read_line2.byte_3f", bd[0][7:0], 8'h3F);
        check("read_line2.byte_40", bd[1][511:504], 8'h40);
        check("read_line2.last_byte", bd[1][7:0], 8'h7F);

        d = mdl_line(4);
        run_cmd("write_line4", CMD_WRITE_NA, 8'h03, 12'd8, 64'h208, '1);
        mem_peek_line = 6'd4; #1;
        check("write_line4.bytes8_15", mem_peek_data[1023-64 -: 64], 64'hFFFF_FFFF_FFFF_FFFF);
        check("write_line4.bytes0_7", mem_peek_data[1023 -: 64], d[1023 -: 64]);
        check("write_line4.byte16", mem_peek_data[1023-128 -: 8], d[1023-128 -: 8]);

        run_cmd("read_line64", CMD_READ_CL_NA, 8'h04, 12'd128, 64'h2000, '0);
        run_cmd("write_cross", CMD_WRITE_NA, 8'h05, 12'd8, 64'h7C, rand_line());
        run_cmd("write_size0", CMD_WRITE_NA, 8'h06, 12'd0, 64'h180, rand_line());
        run_cmd("write_size129", CMD_WRITE_NA, 8'h07, 12'd129, 64'h180, rand_line());
        run_cmd("read_hi_bit", CMD_READ_CL_NA, 8'h08, 12'd16, 64'h8000_0000_0000_0100, '0);
        run_cmd("unknown_cmd", 13'h0001, 8'h09, 12'd16, 64'h100, '0);
        run_cmd("write_tail", CMD_WRITE_NA, 8'h0A, 12'd1, 64'h1FFF, rand_line());

        // One command in flight plus a full FIFO; the sixth back-to-back command is dropped.
        check("ovf.before", overflow, 0);
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #2;
            if (c < 6) drive_cmd(CMD_READ_CL_NA, 8'(8'h10 + c), 12'd128, 64'(c * 128));
            else command_in.valid = 1'b0;
            @(negedge clock);
            if (response.valid) got.push_back(response.tag);
        end
        check("ovf.sticky", overflow, 1);
        check("ovf.nrsp", got.size(), CMD_DEPTH + 1);
        for (int i = 0; i < got.size() && i < CMD_DEPTH + 1; i++)
            check("ovf.order", got[i], 8'(8'h10 + i));

        @(posedge clock); #2;
        drive_cmd(CMD_READ_CL_NA, 8'h20, 12'd128, 64'(5 * 128));
        @(posedge clock); #2;
        command_in.valid = 1'b0;
        @(posedge clock); #2;
        @(negedge clock);
        check("rst_mid.beat0", buffer_out.write_valid, 1);
        @(posedge clock); #2;
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid.beat1_addr", buffer_out.write_address, 1);
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid.buf_zero", 64'(buffer_out === '0), 1);
        check("rst_mid.rsp_zero", 64'(response === '0), 1);
        check("rst_mid.ovf_clear", overflow, 0);
        nrsp = 0;
        repeat (10) begin
            @(negedge clock);
            if (response.valid) nrsp++;
        end
        check("rst_mid.no_rsp", nrsp, 0);
        run_cmd("rst_mid.reread", CMD_READ_CL_NA, 8'h21, 12'd128, 64'(5 * 128), '0);

        // Backdoor load coinciding with the merge of a write to the same line wins.
        afu_line = rand_line();
        d = rand_line();
        @(posedge clock); #2;
        drive_cmd(CMD_WRITE_NA, 8'h30, 12'd128, 64'(7 * 128));
        @(posedge clock); #2;
        command_in.valid = 1'b0;
        repeat (2 + READ_LATENCY) @(posedge clock);
        #2;
        mem_load_en = 1'b1; mem_load_line = 6'd7; mem_load_data = d;
        @(posedge clock); #2;
        mem_load_en = 1'b0;
        @(negedge clock);
        check("bd_prio.rsp", response.valid, 1);
        check("bd_prio.code", response.response, 8'h00);
        for (int b = 0; b < 128; b++) mdl[7][b] = d[1023-8*b -: 8];
        peek_check("bd_prio.mem", 7);

        for (int i = 0; i < 40; i++) begin
            logic [12:0] c;
            logic [11:0] s;
            logic [63:0] a;
            int l = int'($urandom % MEM_LINES);
            int off = int'($urandom % 128);
            case ($urandom % 8)
                0, 1, 2: c = CMD_READ_CL_NA;
                3, 4, 5: c = CMD_WRITE_NA;
                default: c = 13'($urandom % 16'h0A00);
            endcase
            case ($urandom % 10)
                0:       a = 64'(MEM_LINES + int'($urandom % (128 - MEM_LINES))) * 128 + 64'(off);
                1:       a = (64'd1 << (14 + $urandom % 50)) | 64'(l * 128 + off);
                default: a = 64'(l * 128 + off);
            endcase
            case ($urandom % 8)
                0:       s = 12'd0;
                1:       s = 12'(129 + $urandom % 100);
                default: s = 12'(1 + $urandom % (128 - off));
            endcase
            run_cmd("random", c, 8'($urandom), s, a, rand_line());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
